// File: rtl/riu_pkg.sv
// riu_pkg: shared types and constants for the lab_riu fetch stage.
//   fetch_state_t   : fetch sequencer states (BOOT, RUN, HOLD, FLUSH)
//   OP_*            : opcodes the core implements
//   NOP_INSTR       : canonical NOP (addi x0, x0, 0)
//   is_legal_opcode : 1 when the opcode belongs to the implemented set
package riu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == OP_IMM) || (op == OP_REG) || (op == OP_LUI) || (op == OP_SYSTEM);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding buffer for a word that
// returns from instruction memory while the stage is stalled.
//   clk, rst_n        : clock, asynchronous active-low reset (clears full)
//   load              : capture in_pc/in_instr
//   drain             : entry consumed this edge
//   clear             : discard entry (wins over load and drain)
//   in_pc, in_instr   : word to capture
//   full              : entry holds a live word
//   buf_pc, buf_instr : stored word
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        full,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while full is set.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      buf_pc    <= in_pc;
      buf_instr <= in_instr;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the lab_riu RV32 core. Holds the fetch PC,
// drives a 1-cycle synchronous instruction memory, buffers a returning word
// across downstream stalls, honours PC redirects and splits the instruction
// in the output register into decode fields.
// Optional feature macro: IFETCH_ILLEGAL_CHECK_EN (adds illegal_instr; words
// with an unimplemented opcode are replaced by NOP in the output register).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_rd, imem_addr          : read strobe and word address (data next cycle)
//   imem_rdata                  : instruction word returned by memory
//   stall                       : downstream hold, output register frozen
//   redirect_valid, redirect_pc : replace the fetch PC (bits [1:0] ignored)
//   instr_valid, pc_out         : output register holds a live instruction / its PC
//   opcode..imm20               : fields of the instruction in the output register
//   illegal_instr               : (macro only) output word had an illegal opcode
module instr_fetch
  import riu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_rd,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          instr_valid,
`ifdef IFETCH_ILLEGAL_CHECK_EN
  output logic                          illegal_instr,
`endif
  output logic [31:0]                   pc_out,
  output logic [6:0]                    opcode,
  output logic [4:0]                    rd,
  output logic [2:0]                    funct3,
  output logic [4:0]                    rs1,
  output logic [4:0]                    rs2,
  output logic [6:0]                    funct7,
  output logic [11:0]                   imm12,
  output logic [19:0]                   imm20
);

  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

  fetch_state_t state;
  logic [31:0]  fpc;
  logic         vld_p1;
  logic [31:0]  pc_p1;
  logic         skid_full;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;
  logic [31:0]  instr_p2;
  logic         skid_load;
  logic         skid_drain;
  logic         out_load;
  logic [31:0]  src_pc;
  logic [31:0]  src_instr;
  logic [31:0]  word_p2;
  logic         unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // ---- p0: issue. The strobe depends on this cycle's stall/redirect, so it
  // is decoded from the state rather than registered.
  assign imem_rd   = ((state == RUN) || (state == FLUSH)) && !stall && !skid_full && !redirect_valid;
  assign imem_addr = fpc[AW+1:2];

  always_ff @(posedge clk) begin
    if (imem_rd) pc_p1 <= fpc;
  end

  // ---- p1: memory return. The skid never holds a word while a read is in
  // flight, so a full skid is always the older word.
  assign skid_load  = !redirect_valid && stall && vld_p1;
  assign skid_drain = !redirect_valid && !stall && skid_full;
  assign out_load   = !redirect_valid && !stall && (skid_full || vld_p1);
  assign src_pc     = skid_full ? skid_pc : pc_p1;
  assign src_instr  = skid_full ? skid_instr : imem_rdata;

`ifdef IFETCH_ILLEGAL_CHECK_EN
  logic src_legal;
  assign src_legal = is_legal_opcode(src_instr[6:0]);
  assign word_p2   = src_legal ? src_instr : NOP_INSTR;
`else
  assign word_p2   = src_instr;
`endif

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (redirect_valid),
    .in_pc     (pc_p1),
    .in_instr  (imem_rdata),
    .full      (skid_full),
    .buf_pc    (skid_pc),
    .buf_instr (skid_instr)
  );

  // ---- p2: sequencer, fetch PC and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      fpc           <= RESET_PC;
      vld_p1        <= 1'b0;
      instr_valid   <= 1'b0;
      pc_out        <= RESET_PC;
      instr_p2      <= NOP_INSTR;
`ifdef IFETCH_ILLEGAL_CHECK_EN
      illegal_instr <= 1'b0;
`endif
    end else begin
      vld_p1 <= imem_rd;
      if (redirect_valid) begin
        // Redirect beats stall and any in-flight return.
        state         <= FLUSH;
        fpc           <= {redirect_pc[31:2], 2'b00};
        instr_valid   <= 1'b0;
`ifdef IFETCH_ILLEGAL_CHECK_EN
        illegal_instr <= 1'b0;
`endif
      end else begin
        if (imem_rd) fpc <= (fpc + 32'd4) & PC_MASK;
        case (state)
          BOOT:       state <= RUN;
          RUN, FLUSH: state <= (stall && vld_p1) ? HOLD : RUN;
          HOLD:       if (!stall) state <= RUN;
          default:    state <= BOOT;
        endcase
        if (!stall) instr_valid <= skid_full || vld_p1;
        if (out_load) begin
          pc_out   <= src_pc;
          instr_p2 <= word_p2;
        end
`ifdef IFETCH_ILLEGAL_CHECK_EN
        if (!stall) illegal_instr <= out_load && !src_legal;
`endif
      end
    end
  end

  assign opcode = instr_p2[6:0];
  assign rd     = instr_p2[11:7];
  assign funct3 = instr_p2[14:12];
  assign rs1    = instr_p2[19:15];
  assign rs2    = instr_p2[24:20];
  assign funct7 = instr_p2[31:25];
  assign imm12  = instr_p2[31:20];
  assign imm20  = instr_p2[31:12];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch (IMEM_DEPTH=128 so address wrap is reachable).
module tb_instr_fetch;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rd;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic [19:0] imm20;
`ifdef IFETCH_ILLEGAL_CHECK_EN
  logic        illegal_instr;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
`ifdef IFETCH_ILLEGAL_CHECK_EN
    .illegal_instr  (illegal_instr),
`endif
    .pc_out         (pc_out),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7),
    .imm12          (imm12),
    .imm20          (imm20)
  );

  // Synchronous instruction memory.
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Reads in flight / waiting are a queue of {pc, cycle the word is available}.
  // A word available in an earlier cycle but not yet taken blocks new reads.
  typedef struct {
    logic [31:0] pc;
    int          ready;
  } rd_t;

  rd_t         m_q[$];
  bit          m_boot;
  bit          m_ov;
  bit          m_ill;
  logic [31:0] m_fpc;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;
  int          cyc;

  function automatic bit m_issue();
    bit waiting;
    waiting = (m_q.size() > 0) && (m_q[0].ready < cyc);
    return !m_boot && !stall && !redirect_valid && !waiting;
  endfunction

  function automatic bit legal_op(input logic [31:0] w);
    return (w[6:0] == 7'h13) || (w[6:0] == 7'h33) || (w[6:0] == 7'h37) || (w[6:0] == 7'h73);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[8:2]];
`ifdef IFETCH_ILLEGAL_CHECK_EN
    if (!legal_op(w)) w = 32'h0000_0013;
`endif
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_boot = 1'b1;
      m_ov   = 1'b0;
      m_ill  = 1'b0;
      m_fpc  = 32'h0;
      cyc    = 0;
    end else begin
      bit iss;
      iss = m_issue();
      if (redirect_valid) begin
        m_q.delete();
        m_ov  = 1'b0;
        m_ill = 1'b0;
        m_fpc = {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        if (m_q.size() > 0 && m_q[0].ready <= cyc) begin
          m_ov     = 1'b1;
          m_opc    = m_q[0].pc;
          m_oinstr = exp_word(m_opc);
          m_ill    = !legal_op(mem[m_opc[8:2]]);
          void'(m_q.pop_front());
        end else begin
          m_ov  = 1'b0;
          m_ill = 1'b0;
        end
      end
      if (iss) begin
        m_q.push_back('{m_fpc, cyc + 1});
        m_fpc = (m_fpc + 32'd4) & 32'h0000_01FF;
      end
      m_boot = 1'b0;
      cyc++;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_pc", pc_out, 32'h0);
      check("rst_instr", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
      check("rst_imem_rd", 32'(imem_rd), 32'h0);
`ifdef IFETCH_ILLEGAL_CHECK_EN
      check("rst_illegal", 32'(illegal_instr), 32'h0);
`endif
    end else begin
      check("m_imem_rd", 32'(imem_rd), 32'(m_issue()));
      if (m_issue()) check("m_imem_addr", 32'(imem_addr), 32'(m_fpc[8:2]));
      check("m_valid", 32'(instr_valid), 32'(m_ov));
      if (m_ov) begin
        check("m_pc", pc_out, m_opc);
        check("m_fields", {funct7, rs2, rs1, funct3, rd, opcode}, m_oinstr);
        check("m_imm12", 32'(imm12), 32'(m_oinstr[31:20]));
        check("m_imm20", 32'(imm20), 32'(m_oinstr[31:12]));
      end
`ifdef IFETCH_ILLEGAL_CHECK_EN
      check("m_illegal", 32'(illegal_instr), 32'(m_ill));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, 32'(instr_valid), 32'(v));
    if (v) check({name, "_pc"}, pc_out, pc);
  endtask

  logic [63:0] stall_pat;

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall_pat      = 64'hC3A5_0F96_1E78_B4D2;
    for (int i = 0; i < DEPTH; i++) mem[i] = (32'(i) << 20) | 32'h0000_0093;
`ifdef IFETCH_ILLEGAL_CHECK_EN
    mem[60] = 32'h0000_006F;
`endif
    tick();
    tick();
    expect_out("lit_reset", 1'b0, 32'h0);
    check("lit_reset_pc", pc_out, 32'h0);
    check("lit_reset_op", 32'(opcode), 32'h13);

    // Reset release, BOOT then free-running stream.
    rst_n = 1'b1;
    #1;
    check("lit_boot_rd", 32'(imem_rd), 32'h0);
    tick();
    check("lit_run_rd", 32'(imem_rd), 32'h1);
    check("lit_run_addr", 32'(imem_addr), 32'h0);
    tick();
    expect_out("lit_lat", 1'b0, 32'h0);
    check("lit_addr1", 32'(imem_addr), 32'h1);
    tick();
    expect_out("lit_first", 1'b1, 32'h0);
    check("lit_first_imm", 32'(imm12), 32'h0);
    tick();
    expect_out("lit_second", 1'b1, 32'h4);
    check("lit_second_imm", 32'(imm12), 32'h1);
    tick();
    tick();
    tick();
    expect_out("lit_pc10", 1'b1, 32'h10);

    // Stall three cycles at pc_out=0x10.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("lit_stall_hold", 1'b1, 32'h10);
    end
    stall = 1'b0;
    tick();
    expect_out("lit_drain", 1'b1, 32'h14);
    tick();
    expect_out("lit_refill", 1'b0, 32'h0);
    tick();
    expect_out("lit_after", 1'b1, 32'h18);

    // Redirect to 0x103.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    #1;
    expect_out("lit_redir_drop", 1'b0, 32'h0);
    check("lit_flush_rd", 32'(imem_rd), 32'h1);
    check("lit_flush_addr", 32'(imem_addr), 32'h40);
    tick();
    expect_out("lit_redir_wait", 1'b0, 32'h0);
    tick();
    expect_out("lit_redir_tgt", 1'b1, 32'h100);

    // Redirect + stall while the skid is full.
    stall = 1'b1;
    tick();
    expect_out("lit_skid_hold", 1'b1, 32'h100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    tick();
    expect_out("lit_rs_drop", 1'b0, 32'h0);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    tick();
    expect_out("lit_rs_wait", 1'b0, 32'h0);
    tick();
    expect_out("lit_rs_tgt", 1'b1, 32'h80);
    tick();
    expect_out("lit_rs_next", 1'b1, 32'h84);

    // Back-to-back redirects: last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    tick();
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    tick();
    expect_out("lit_b2b_wait", 1'b0, 32'h0);
    tick();
    expect_out("lit_b2b_tgt", 1'b1, 32'h40);

    // Address wrap past word 127.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_01F8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    expect_out("lit_wrap_a", 1'b1, 32'h1F8);
    check("lit_wrap_addr", 32'(imem_addr), 32'h0);
    tick();
    expect_out("lit_wrap_b", 1'b1, 32'h1FC);
    tick();
    expect_out("lit_wrap_c", 1'b1, 32'h0);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    expect_out("lit_arst", 1'b0, 32'h0);
    check("lit_arst_pc", pc_out, 32'h0);
    check("lit_arst_rd", 32'(imem_rd), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    expect_out("lit_rerun", 1'b1, 32'h0);

    // Mixed stall / redirect pattern, checked by the model.
    for (int i = 0; i < 90; i++) begin
      stall          = stall_pat[i % 64];
      redirect_valid = (i % 29 == 13);
      redirect_pc    = 32'((i * 52) & 32'h1FC) | 32'h1;
      tick();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (4) tick();

`ifdef IFETCH_ILLEGAL_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00F0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    expect_out("lit_illegal", 1'b1, 32'hF0);
    check("lit_illegal_flag", 32'(illegal_instr), 32'h1);
    check("lit_illegal_op", 32'(opcode), 32'h13);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
